// File: rtl/cs_select_pipe_if.sv
// Stream bus between the nibble adder cells, the carry-select resolver and its consumer.
// master = upstream/downstream environment, slave = cs_select_pipe.
interface cs_select_pipe_if #(
    parameter int WIDTH       = 32,
    parameter int NIBBLE_SIZE = 4
);
    localparam int NUM_NIBBLES = WIDTH / NIBBLE_SIZE;

    logic                   valid_i;
    logic                   ready_o;
    logic                   cin_i;
    logic [WIDTH-1:0]       h0_sum_i;
    logic [WIDTH-1:0]       h1_sum_i;
    logic [NUM_NIBBLES-1:0] h0_carry_i;
    logic [NUM_NIBBLES-1:0] h1_carry_i;
    logic                   valid_o;
    logic                   ready_i;
    logic [WIDTH-1:0]       sum_o;
    logic                   cout_o;

    modport master (
        output valid_i, cin_i, h0_sum_i, h1_sum_i, h0_carry_i, h1_carry_i, ready_i,
        input  ready_o, valid_o, sum_o, cout_o
    );

    modport slave (
        input  valid_i, cin_i, h0_sum_i, h1_sum_i, h0_carry_i, h1_carry_i, ready_i,
        output ready_o, valid_o, sum_o, cout_o
    );
endinterface

// File: rtl/cs_select_pipe.sv
// Two-stage carry-select resolver: S1 resolves the lower half, S2 the upper half and carry-out.
// Optional macro CS_SELECT_SKID_EN adds a one-entry skid buffer so ready_o comes from a flop.
module cs_select_pipe #(
    parameter int WIDTH       = 32,
    parameter int NIBBLE_SIZE = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    cs_select_pipe_if.slave   bus
);
    localparam int NUM_NIBBLES = WIDTH / NIBBLE_SIZE;
    localparam int HALF_N      = NUM_NIBBLES / 2;
    localparam int HALF_W      = WIDTH / 2;

    generate
        if (WIDTH % (2 * NIBBLE_SIZE) != 0) begin : g_bad_width
            $error("cs_select_pipe: WIDTH must be a multiple of 2*NIBBLE_SIZE");
        end
    endgenerate

    logic                   s1_en;
    logic                   s2_en;
    logic                   in_xfer;
    logic                   src_valid;
    logic                   src_cin;
    logic [WIDTH-1:0]       src_h0;
    logic [WIDTH-1:0]       src_h1;
    logic [NUM_NIBBLES-1:0] src_h0c;
    logic [NUM_NIBBLES-1:0] src_h1c;

    logic                   s1_valid_reg;
    logic [HALF_W-1:0]      s1_sum_lo_reg;
    logic                   s1_mid_c_reg;
    logic [HALF_W-1:0]      s1_h0_hi_reg;
    logic [HALF_W-1:0]      s1_h1_hi_reg;
    logic [HALF_N-1:0]      s1_h0c_hi_reg;
    logic [HALF_N-1:0]      s1_h1c_hi_reg;

    logic                   valid_o_reg;
    logic [WIDTH-1:0]       sum_o_reg;
    logic                   cout_o_reg;

    assign s2_en   = ~valid_o_reg | bus.ready_i;
    assign s1_en   = ~s1_valid_reg | s2_en;
    assign in_xfer = bus.valid_i & bus.ready_o;

`ifdef CS_SELECT_SKID_EN
    logic                   skid_valid_reg;
    logic                   skid_cin_reg;
    logic [WIDTH-1:0]       skid_h0_reg;
    logic [WIDTH-1:0]       skid_h1_reg;
    logic [NUM_NIBBLES-1:0] skid_h0c_reg;
    logic [NUM_NIBBLES-1:0] skid_h1c_reg;

    assign bus.ready_o = ~skid_valid_reg;
    // A parked entry always goes to S1 ahead of the live input (which is blocked meanwhile).
    assign src_valid   = skid_valid_reg | bus.valid_i;
    assign src_cin     = skid_valid_reg ? skid_cin_reg : bus.cin_i;
    assign src_h0      = skid_valid_reg ? skid_h0_reg  : bus.h0_sum_i;
    assign src_h1      = skid_valid_reg ? skid_h1_reg  : bus.h1_sum_i;
    assign src_h0c     = skid_valid_reg ? skid_h0c_reg : bus.h0_carry_i;
    assign src_h1c     = skid_valid_reg ? skid_h1c_reg : bus.h1_carry_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            if (s1_en) begin
                skid_valid_reg <= 1'b0;
            end
        end else if (in_xfer && !s1_en) begin
            skid_valid_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!skid_valid_reg && in_xfer && !s1_en) begin
            skid_cin_reg <= bus.cin_i;
            skid_h0_reg  <= bus.h0_sum_i;
            skid_h1_reg  <= bus.h1_sum_i;
            skid_h0c_reg <= bus.h0_carry_i;
            skid_h1c_reg <= bus.h1_carry_i;
        end
    end
`else
    assign bus.ready_o = s1_en;
    assign src_valid   = bus.valid_i;
    assign src_cin     = bus.cin_i;
    assign src_h0      = bus.h0_sum_i;
    assign src_h1      = bus.h1_sum_i;
    assign src_h0c     = bus.h0_carry_i;
    assign src_h1c     = bus.h1_carry_i;
`endif

    // Carry into each nibble; index HALF_N is the carry out of the half.
    logic [HALF_N:0]   lo_c;
    logic [HALF_N:0]   hi_c;
    logic [HALF_W-1:0] lo_sum;
    logic [HALF_W-1:0] hi_sum;

    always_comb begin
        lo_c    = '0;
        lo_c[0] = src_cin;
        for (int k = 0; k < HALF_N; k++) begin
            lo_c[k+1] = lo_c[k] ? src_h1c[k] : src_h0c[k];
        end
    end

    always_comb begin
        hi_c    = '0;
        hi_c[0] = s1_mid_c_reg;
        for (int k = 0; k < HALF_N; k++) begin
            hi_c[k+1] = hi_c[k] ? s1_h1c_hi_reg[k] : s1_h0c_hi_reg[k];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < HALF_N; gi++) begin : g_nibble
            assign lo_sum[gi*NIBBLE_SIZE +: NIBBLE_SIZE] = lo_c[gi]
                ? src_h1[gi*NIBBLE_SIZE +: NIBBLE_SIZE]
                : src_h0[gi*NIBBLE_SIZE +: NIBBLE_SIZE];
            assign hi_sum[gi*NIBBLE_SIZE +: NIBBLE_SIZE] = hi_c[gi]
                ? s1_h1_hi_reg[gi*NIBBLE_SIZE +: NIBBLE_SIZE]
                : s1_h0_hi_reg[gi*NIBBLE_SIZE +: NIBBLE_SIZE];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_reg <= 1'b0;
            valid_o_reg  <= 1'b0;
            sum_o_reg    <= '0;
            cout_o_reg   <= 1'b0;
        end else begin
            if (s2_en) begin
                valid_o_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    sum_o_reg  <= {hi_sum, s1_sum_lo_reg};
                    cout_o_reg <= hi_c[HALF_N];
                end
            end
            if (s1_en) begin
                s1_valid_reg <= src_valid;
            end
        end
    end

    // S1 payload needs no reset: it is only consumed behind s1_valid_reg.
    always_ff @(posedge clk_i) begin
        if (s1_en && src_valid) begin
            s1_sum_lo_reg <= lo_sum;
            s1_mid_c_reg  <= lo_c[HALF_N];
            s1_h0_hi_reg  <= src_h0[WIDTH-1:HALF_W];
            s1_h1_hi_reg  <= src_h1[WIDTH-1:HALF_W];
            s1_h0c_hi_reg <= src_h0c[NUM_NIBBLES-1:HALF_N];
            s1_h1c_hi_reg <= src_h1c[NUM_NIBBLES-1:HALF_N];
        end
    end

    assign bus.valid_o = valid_o_reg;
    assign bus.sum_o   = sum_o_reg;
    assign bus.cout_o  = cout_o_reg;
endmodule

// File: tb/tb_cs_select_pipe.sv
// Randomized bench for cs_select_pipe: nibble cells modelled from A/B, results scored against A+B+cin.
module tb_cs_select_pipe;
    localparam int WIDTH = 32;
    localparam int NS    = 4;
    localparam int NN    = WIDTH / NS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cs_select_pipe_if #(.WIDTH(WIDTH), .NIBBLE_SIZE(NS)) bus ();

    cs_select_pipe #(.WIDTH(WIDTH), .NIBBLE_SIZE(NS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int              checks_cnt = 0;
    int              errors_cnt = 0;
    logic [WIDTH:0]  exp_q[$];
    logic            prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_sum;
    logic            prev_cout;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Upstream nibble cells: each nibble adds A_k+B_k with carry-in 0 and 1.
    task automatic drive_nibbles(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
        for (int k = 0; k < NN; k++) begin
            logic [NS:0] s0;
            logic [NS:0] s1;
            s0 = {1'b0, a[k*NS +: NS]} + {1'b0, b[k*NS +: NS]};
            s1 = s0 + 1'b1;
            bus.h0_sum_i[k*NS +: NS] = s0[NS-1:0];
            bus.h1_sum_i[k*NS +: NS] = s1[NS-1:0];
            bus.h0_carry_i[k]        = s0[NS];
            bus.h1_carry_i[k]        = s1[NS];
        end
        bus.cin_i = cin;
    endtask

    // One clock: drive at negedge, score transfers just after, then advance to the posedge.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic rdy, input logic do_rst);
        logic           pre_ready;
        logic [WIDTH:0] exp;
        @(negedge clk);
        pre_ready   = bus.ready_o;
        rst         = do_rst;
        bus.valid_i = v;
        bus.ready_i = rdy;
        drive_nibbles(a, b, cin);
        #1;
        if (!do_rst) begin
            if (prev_stall) begin
                check("hold_valid", bus.valid_o, 1);
                check("hold_sum", bus.sum_o, prev_sum);
                check("hold_cout", bus.cout_o, prev_cout);
            end
`ifdef CS_SELECT_SKID_EN
            check("ready_from_flop", bus.ready_o, pre_ready);
            check("occupancy", exp_q.size() <= 3, 1);
`else
            check("ready_o", bus.ready_o, !(exp_q.size() == 2 && !rdy));
`endif
            if (bus.valid_o && rdy) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("sum", bus.sum_o, exp[WIDTH-1:0]);
                    check("cout", bus.cout_o, exp[WIDTH]);
                end
            end
            if (v && bus.ready_o) begin
                exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin});
            end
        end
        prev_stall = bus.valid_o & ~rdy & ~do_rst;
        prev_sum   = bus.sum_o;
        prev_cout  = bus.cout_o;
        @(posedge clk);
        if (do_rst) begin
            exp_q.delete();
        end
    endtask

    // Single transfer into an empty pipe: result must appear exactly two cycles later.
    task automatic send_check(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic cin, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        cycle(1'b1, a, b, cin, 1'b1, 1'b0);
        #1 check({tag, "_lat1"}, bus.valid_o, 0);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        #1 check({tag, "_lat2"}, bus.valid_o, 1);
        check({tag, "_sum"}, bus.sum_o, exp_sum);
        check({tag, "_cout"}, bus.cout_o, exp_cout);
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        end
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;

        rst         = 1'b1;
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b1;
        drive_nibbles($urandom, $urandom, 1'b0);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1, 1'b1);
            #1;
            check("rst_valid_o", bus.valid_o, 0);
            check("rst_sum_o", bus.sum_o, 0);
            check("rst_cout_o", bus.cout_o, 0);
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.valid_i = 1'b0;
        #1 check("rst_ready_o", bus.ready_o, 1);
        prev_stall = 1'b0;

        send_check("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        send_check("cin_half", 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0);
        send_check("cin_zero", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0);

        for (int i = 0; i < 102; i++) begin
            cycle(i < 100, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            #1 check("stream_no_bubble", bus.valid_o, (i >= 1 && i <= 100));
        end
        drain("stream_drained");

        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), !(i >= 5 && i < 10), 1'b0);
        end
        drain("bp_drained");

        cycle(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        #1 check("mrst_valid_o", bus.valid_o, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        end
        ra = $urandom;
        rb = $urandom;
        rc = 1'($urandom_range(0, 1));
        begin
            logic [WIDTH:0] full;
            full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            send_check("mrst_next", ra, rb, rc, full[WIDTH-1:0], full[WIDTH]);
        end

        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), 1'b0);
        end
        drain("rand_drained");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
